// File: rtl/hpm_counter_unit_if.sv
// hpm_counter_unit_if: CSR access bus between the CSR file (master) and the HPM counter unit (slave)
// csr_addr_i/csr_we_i/csr_wdata_i/priv_lvl_i driven by the CSR file; csr_rdata_o/csr_hit_o/csr_illegal_o returned combinationally
interface hpm_counter_unit_if;
  logic [11:0] csr_addr_i;
  logic        csr_we_i;
  logic [31:0] csr_wdata_i;
  logic [1:0]  priv_lvl_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;
  logic        csr_illegal_o;
  modport master (
    output csr_addr_i, csr_we_i, csr_wdata_i, priv_lvl_i,
    input  csr_rdata_o, csr_hit_o, csr_illegal_o
  );
  modport slave (
    input  csr_addr_i, csr_we_i, csr_wdata_i, priv_lvl_i,
    output csr_rdata_o, csr_hit_o, csr_illegal_o
  );
endinterface

// File: rtl/hpm_counter_unit.sv
// hpm_counter_unit: machine performance counters (mcycle, minstret, mhpmcounterN) with CSR access and user shadows
// clk/rst: core clock, synchronous active-high reset; bus: CSR access (slave)
// instr_retired_i: one retirement this cycle; event_i: one-cycle event pulses selected by mhpmeventN
module hpm_counter_unit #(
  parameter int NUM_HPM       = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hpm_counter_unit_if.slave     bus,
  input  logic                  instr_retired_i,
  input  logic [NUM_EVENTS-1:0] event_i
);
  localparam int CW = COUNTER_WIDTH;
  localparam int EW = $clog2(NUM_EVENTS + 1);
  // implemented counter indices: mcycle, minstret and mhpmcounter3..3+NUM_HPM-1
  localparam logic [31:0] IMP = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
  logic [11:0] a;
  logic [4:0] idx;
  logic m_lo, m_hi, u_lo, u_hi, cnt_sel, evt_sel, inh_sel, en_sel;
  logic hit, ill, wr, m_priv;
  logic [31:0] inh_q, en_q, val;
  logic [CW-1:0] c;
  logic [CW-1:0] cnt [32];
  logic [EW-1:0] evt [32];
  logic [NUM_EVENTS:0] ev_ext;
  assign a       = bus.csr_addr_i;
  assign idx     = a[4:0];
  assign m_priv  = bus.priv_lvl_i == 2'b11;
  assign m_lo    = a[11:5] == 7'h58;
  assign m_hi    = a[11:5] == 7'h5c;
  assign u_lo    = a[11:5] == 7'h60;
  assign u_hi    = a[11:5] == 7'h64;
  // index 1 (time) is not owned here
  assign cnt_sel = (m_lo | m_hi | u_lo | u_hi) & (idx != 5'd1);
  assign evt_sel = (a[11:5] == 7'h19) & (idx >= 5'd3);
  assign inh_sel = a == 12'h320;
  assign en_sel  = a == 12'h306;
  assign hit     = cnt_sel | evt_sel | inh_sel | en_sel;
  assign ill     = hit & ((u_lo | u_hi) ? (bus.csr_we_i | (~m_priv & ~en_q[idx])) : ~m_priv);
  assign wr      = bus.csr_we_i & hit & ~ill;
  // event e selects event_i[e-1]; slot 0 never fires
  assign ev_ext  = {event_i, 1'b0};
  always_ff @(posedge clk)
    if (rst) begin
      inh_q <= '0;
      en_q  <= '0;
    end else begin
      if (wr & inh_sel) inh_q <= bus.csr_wdata_i & IMP;
      if (wr & en_sel) en_q <= bus.csr_wdata_i & IMP;
    end
  for (genvar g = 0; g < 32; g++) begin : g_k
    if (IMP[g]) begin : g_c
      logic [CW-1:0] cnt_q, cnt_d;
      logic inc, wr_lo, wr_hi;
      if (g == 0) begin : g_cy
        assign inc    = 1'b1;
        assign evt[g] = '0;
      end else if (g == 2) begin : g_ir
        assign inc    = instr_retired_i;
        assign evt[g] = '0;
      end else begin : g_ev
        logic [EW-1:0] evt_q;
        always_ff @(posedge clk)
          if (rst) evt_q <= '0;
          else if (wr & evt_sel & (idx == 5'(g))) evt_q <= bus.csr_wdata_i[EW-1:0];
        assign inc    = (evt_q <= EW'(NUM_EVENTS)) & ev_ext[evt_q];
        assign evt[g] = evt_q;
      end
      assign wr_lo = wr & m_lo & (idx == 5'(g));
      assign wr_hi = wr & m_hi & (idx == 5'(g));
      // a write to either half replaces that cycle's increment entirely
      assign cnt_d = wr_lo ? {cnt_q[CW-1:32], bus.csr_wdata_i} :
                     wr_hi ? {bus.csr_wdata_i[CW-33:0], cnt_q[31:0]} :
                     cnt_q + CW'(inc & ~inh_q[g]);
      always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
      assign cnt[g] = cnt_q;
    end else begin : g_z
      assign cnt[g] = '0;
      assign evt[g] = '0;
    end
  end
  always_comb begin
    c   = cnt[idx];
    val = cnt_sel ? ((m_hi | u_hi) ? 32'(c[CW-1:32]) : c[31:0]) :
          evt_sel ? 32'(evt[idx]) :
          inh_sel ? inh_q : en_q;
  end
  assign bus.csr_rdata_o   = (hit & ~ill) ? val : 32'h0;
  assign bus.csr_hit_o     = hit;
  assign bus.csr_illegal_o = ill;
endmodule

// File: doc/hpm_counter_unit.md
Name: hpm_counter_unit

Overview:
Parametrised machine hardware-performance-monitor block. It holds mcycle, minstret and NUM_HPM general event counters mhpmcounter3..(3+NUM_HPM-1), along with their event selectors, mcountinhibit and mcounteren. It serves the CSR read/write path from the CSR file, including the read-only user shadows (cycle/instret/hpmcounterN and their H halves) with privilege checking. It sits beside the CSR file in the WB stage.

Parameters:
NUM_HPM, 4, number of implemented event counters (0..29); counters 3+NUM_HPM..31 are hardwired zero.
COUNTER_WIDTH, 64, implemented counter width (33..64); bits above the width read zero.
NUM_EVENTS, 16, width of event_i (1..31).

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
csr_addr_i  in  12  CSR address (csr_addr_t encoding)
csr_we_i  in  1  write strobe; csr_wdata_i is the final value after SET/CLEAR resolution
csr_wdata_i  in  32  write data
priv_lvl_i  in  2  current privilege (2'b11 = M, 2'b00 = U)
csr_rdata_o  out  32  read data (combinational)
csr_hit_o  out  1  csr_addr_i decodes to a register owned by this block
csr_illegal_o  out  1  access must raise illegal instruction
instr_retired_i  in  1  one instruction retires this cycle
event_i  in  NUM_EVENTS  one-cycle event pulses

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On rst, all counters, mhpmevent*, mcountinhibit and mcounteren are cleared to 0. No output is registered: csr_rdata_o, csr_hit_o and csr_illegal_o are combinational. With csr_addr_i = 0 they are 0/0/0 during reset.
- mcycle: increments by 1 every cycle unless mcountinhibit[0] is set.
- minstret: increments by 1 when instr_retired_i is high, unless mcountinhibit[2] is set.
- mhpmcounterK: increments by 1 when mhpmeventK = e, 1 <= e <= NUM_EVENTS, event_i[e-1] is high, and mcountinhibit[K] is clear.
  - e = 0 or e > NUM_EVENTS counts nothing.
  - mhpmeventK is WARL: it stores only the low clog2(NUM_EVENTS+1) bits and reads them back.
- mcountinhibit:
  - bit 1 is hardwired 0;
  - bits for unimplemented counters are hardwired 0;
  - other bits are R/W.
- mcounteren: same implemented-bit mask as mcountinhibit.
- Counter wrap: counters wrap modulo 2^COUNTER_WIDTH with no sticky overflow.
- Halves: the low CSR (B00/B02/B0x) accesses bits [31:0]. The H CSR (B8x) accesses bits [COUNTER_WIDTH-1:32], zero-extended on read.
- Write vs increment (same cycle):
  - A write to either half takes priority over that cycle's increment for the whole counter; no increment is applied that cycle.
  - Writing the low half leaves the high half at its pre-write value, with no carry into it.
  - Writing the high half leaves the low half at its pre-write value.
- Read timing: csr_rdata_o returns the pre-update (current register) value in the same cycle.
- User shadows (C00-C1F, C80-C9F): read-only views of the corresponding machine counter.
  - Illegal when csr_we_i = 1.
  - Illegal when priv_lvl_i != M and mcounteren[index] = 0.
  - Counts continue when the access is illegal.
- Legality and illegal-access behaviour:
  - Machine counter CSRs are illegal when priv_lvl_i != M.
  - Unimplemented counter indices (3+NUM_HPM..31, machine or user) are hit, read 0, ignore writes, and are not illegal in M.
  - When csr_illegal_o = 1, the write is suppressed and csr_rdata_o = 0.
- Hit decode: addresses not owned by this block give csr_hit_o = 0 and csr_rdata_o = 0; writes to them are ignored.
- Reset mid-operation: rst wins over any same-cycle write or increment.

Test Plan:
1. Reset, then 10 idle cycles in M; read B00 -> 10, B80 -> 0, B02 -> 0; read 320 -> 0.
2. Write B00 = 0xFFFF_FFFE, then idle 3 cycles; read B00 -> 0x0000_0001, B80 -> 1 (carry through the low half). Write B80 = 5 in the same cycle as a count: B80 -> 5, and the low half holds with no increment that cycle.
3. Write 323 = 3, pulse event_i[2] for 4 cycles and event_i[0] for 2 cycles; read B03 -> 4. Set mcountinhibit[3] and pulse event_i[2] again -> B03 stays 4. Write 320 = 0xFFFF_FFFF -> reads 0x0000_007D with NUM_HPM = 4.
4. Assert instr_retired_i on 7 of 12 cycles -> B02 = 7. With mcountinhibit[2] = 1 -> B02 frozen while mcycle keeps counting.
5. priv_lvl_i = U with mcounteren = 0: read C00 -> csr_illegal_o = 1, rdata = 0. Set mcounteren = 1: read C00 -> legal, equals mcycle. Write C00 in M -> illegal, counter unchanged. Read B00 in U -> illegal.
6. Read B10 with NUM_HPM = 4 in M -> hit = 1, 0, not illegal; write B10 -> ignored. Assert rst together with a B00 write -> all counters 0 next cycle.
